// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared codes, glyphs and scan states
// for the two-digit seven-segment scan driver.
package seg_scan_pkg;

  localparam logic [3:0] CODE_NOFUND = 4'hA;
  localparam logic [3:0] CODE_IDLE   = 4'hB;
  localparam logic [3:0] CODE_BLANK  = 4'hD;
  localparam logic [3:0] CODE_PASS   = 4'hF;

  // High-true glyphs {g,f,e,d,c,b,a}, indexed by code.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h73, 7'h79, 7'h00, 7'h39,
    7'h40, 7'h54, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } code_pair_t;

  typedef enum logic [2:0] {
    S_OFF,
    S_T,
    S_GT,
    S_U,
    S_GU
  } state_t;

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: 4-bit digit code to high-true
// seven-segment glyph, purely combinational.
module seg_glyph_rom
  import seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TAB[code];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: latches a code pair, scans two digits with dead time.
// Define SEG_SCAN_BLINK_EN to blink both digits while a code is 'n'.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int GAP            = 2,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int BLINK_FRAMES   = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] tens_code,
  input  logic [3:0] units_code,
  input  logic       load,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CW =
    $clog2((SCAN_DIV > GAP) ? SCAN_DIV : GAP);
  localparam logic [CW-1:0] DIV_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP - 1);
  localparam logic [6:0] SEG_OFF =
    (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  code_pair_t    shadow, active;
  code_pair_t    incoming, next_pair;
  logic          frame_start, lz, lit;
  logic          blank_all;
  logic [3:0]    tens_eff, code_sel;
  logic [6:0]    glyph, glyph_lit, seg_n;
  logic [1:0]    an_n;

  assign incoming  = {tens_code, units_code};
  assign next_pair = load ? incoming : shadow;

  // Scan sequencing: next state and slot counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    if (!enable) begin
      state_n = S_OFF;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_n = S_T;
          cnt_n   = '0;
        end
        S_T: if (cnt == DIV_LAST) begin
          state_n = S_GT;
          cnt_n   = '0;
        end
        S_GT: if (cnt == GAP_LAST) begin
          state_n = S_U;
          cnt_n   = '0;
        end
        S_U: if (cnt == DIV_LAST) begin
          state_n = S_GU;
          cnt_n   = '0;
        end
        S_GU: if (cnt == GAP_LAST) begin
          state_n = S_T;
          cnt_n   = '0;
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign frame_start =
    (state_n == S_T) && (state != S_T);

  // State and slot counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Shadow takes every load; active only at frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= {CODE_BLANK, CODE_BLANK};
      active <= {CODE_BLANK, CODE_BLANK};
    end else begin
      if (load)
        shadow <= incoming;
      if (frame_start)
        active <= next_pair;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST =
    FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt;
  logic          blink_off;

  // Blink half-period tracker; a new pair restarts it lit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt      <= '0;
      blink_off <= 1'b0;
    end else if (frame_start) begin
      if (next_pair != active) begin
        fcnt      <= '0;
        blink_off <= 1'b0;
      end else if (fcnt == F_LAST) begin
        fcnt      <= '0;
        blink_off <= ~blink_off;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blank_all = blink_off &&
    ((active.tens == CODE_NOFUND) ||
     (active.units == CODE_NOFUND));
`else
  logic blink_unused;
  assign blink_unused = (BLINK_FRAMES > 0);
  assign blank_all    = 1'b0;
`endif

  assign lz = (active.tens == 4'h0) &&
              (active.units <= 4'h9);
  assign tens_eff = lz ? CODE_BLANK : active.tens;
  assign code_sel =
    (state == S_U) ? active.units : tens_eff;

  seg_glyph_rom u_rom (
    .code  (code_sel),
    .glyph (glyph)
  );

  assign lit = (state == S_T) || (state == S_U);
  assign glyph_lit =
    (lit && !blank_all) ? glyph : 7'h00;
  assign seg_n = (ACTIVE_LOW_SEG != 0) ?
    ~glyph_lit : glyph_lit;
  assign an_n = (state == S_T) ? 2'b01 :
                (state == S_U) ? 2'b10 : 2'b11;

  // Registered pin drivers; enable low darkens at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg        <= SEG_OFF;
      an         <= 2'b11;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      seg        <= SEG_OFF;
      an         <= 2'b11;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_n;
      an         <= an_n;
      frame_tick <= (state == S_T) && (cnt == '0);
    end
  end

  assign dp = (ACTIVE_LOW_SEG != 0);

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench, per-frame monitor.
// SCAN_DIV=4, GAP=1, active-low segments, BLINK_FRAMES=2.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] tens_code = 4'h0;
  logic [3:0] units_code = 4'h0;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       frame_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV       (4),
    .GAP            (1),
    .ACTIVE_LOW_SEG (1),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tens_code  (tens_code),
    .units_code (units_code),
    .load       (load),
    .enable     (enable),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int         tgt;
    logic [6:0] t;
    logic [6:0] u;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   frame_no = 0;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic push(int tgt,
                      logic [6:0] t,
                      logic [6:0] u);
    exp_t e;
    e.tgt = tgt;
    e.t   = t;
    e.u   = u;
    sb.push_back(e);
  endtask

  // Monitor: one frame is 10 output cycles.
  bit         in_frame = 0;
  bit         shape_ok = 0;
  int         pos = 0;
  int         fidx = 0;
  logic [6:0] st, su;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n || !enable) begin
      in_frame = 0;
    end else begin
      if (frame_tick) begin
        if (in_frame)
          chk("frame_period", pos, 10);
        in_frame = 1;
        pos      = 0;
        fidx     = frame_no;
        frame_no++;
        shape_ok = 1;
        st       = seg;
      end
      if (in_frame && pos < 10) begin
        if (pos == 5)
          su = seg;
        if (dp !== 1'b1)
          shape_ok = 0;
        if (pos < 4) begin
          if (an !== 2'b01 || seg !== st)
            shape_ok = 0;
        end else if (pos == 4 || pos == 9) begin
          if (an !== 2'b11 || seg !== 7'h7F)
            shape_ok = 0;
        end else begin
          if (an !== 2'b10 || seg !== su)
            shape_ok = 0;
        end
        if (pos == 9) begin
          while (sb.size() > 0 &&
                 sb[0].tgt < fidx) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL frame_missed: frame %0d not seen",
                     e.tgt);
          end
          if (sb.size() > 0 &&
              sb[0].tgt == fidx) begin
            e = sb.pop_front();
            chk("frame_shape", {31'd0, shape_ok}, 1);
            chk("tens_seg", st, e.t);
            chk("units_seg", su, e.u);
          end
        end
      end
      if (in_frame)
        pos++;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_tick && n < 40);
    chk("tick_seen", frame_tick, 1);
  endtask

  task automatic do_load(logic [3:0] t,
                         logic [3:0] u);
    tens_code  = t;
    units_code = u;
    load       = 1'b1;
    cyc(1);
    load       = 1'b0;
  endtask

  initial begin
    int nx;
    // Reset state.
    cyc(3);
    chk("rst_an", an, 2'b11);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Asynchronous reset mid units slot.
    wait_tick();
    cyc(5);
    chk("pre_rst_an", an, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_an", an, 2'b11);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    chk("arst_tick", frame_tick, 1'b0);
    cyc(1);
    enable  = 1'b0;
    reset_n = 1'b1;
    cyc(1);

    // 1,5 shown from first frame.
    do_load(4'h1, 4'h5);
    push(frame_no, 7'h79, 7'h12);
    push(frame_no + 1, 7'h79, 7'h12);
    enable = 1'b1;
    repeat (3) wait_tick();

    // Leading zero blanked.
    cyc(3);
    do_load(4'h0, 4'h7);
    push(frame_no, 7'h7F, 7'h78);
    push(frame_no + 1, 7'h7F, 7'h78);
    repeat (3) wait_tick();

    // Mid-frame load: old pair finishes.
    cyc(3);
    push(frame_no - 1, 7'h7F, 7'h78);
    do_load(4'hA, 4'h0);
    nx = frame_no;
`ifdef SEG_SCAN_BLINK_EN
    push(nx, 7'h2B, 7'h40);
    push(nx + 1, 7'h2B, 7'h40);
    push(nx + 2, 7'h7F, 7'h7F);
    push(nx + 3, 7'h7F, 7'h7F);
`else
    for (int i = 0; i < 4; i++)
      push(nx + i, 7'h2B, 7'h40);
`endif
    repeat (5) wait_tick();

    // Two loads in one frame: last wins.
    cyc(3);
    do_load(4'hB, 4'hB);
    cyc(1);
    do_load(4'hF, 4'h0);
    push(frame_no, 7'h0C, 7'h40);
    push(frame_no + 1, 7'h0C, 7'h40);
    repeat (2) wait_tick();

    // Load on the frame-start edge.
    cyc(8);
    push(frame_no, 7'h24, 7'h30);
    do_load(4'h2, 4'h3);
    repeat (2) wait_tick();

    // Enable dropped mid tens slot.
    cyc(1);
    enable = 1'b0;
    cyc(1);
    chk("dis_an", an, 2'b11);
    chk("dis_seg", seg, 7'h7F);
    chk("dis_tick", frame_tick, 1'b0);
    enable = 1'b1;
    push(frame_no, 7'h24, 7'h30);
    wait_tick();
    chk("restart_an", an, 2'b01);
    cyc(12);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
